// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// the flag bundle, and a small opcode-class helper.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOTA = 4'h5,
        OP_NOTB = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ASR  = 4'h9,
        OP_ADC  = 4'hA,
        OP_SBC  = 4'hB,
        OP_CMP  = 4'hC,
        OP_MUL  = 4'hD,
        OP_RSVE = 4'hE,
        OP_RSVF = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Flags of an all-zero result: what reset leaves on the outputs.
    localparam flags_t FLAGS_RST = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle combinational datapath: add/sub family, logic ops and their
// flags. Any opcode it does not implement yields the reserved result
// (0 with Z set).
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output flags_t           flg
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] fsrc;
    logic             carry;
    logic             ovf;

    // Result, carry/borrow and overflow; Z/N come from the flag source,
    // which for CMP is the difference rather than the returned operand.
    always_comb begin
        wide  = '0;
        res   = '0;
        fsrc  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                wide  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
                res   = wide[WIDTH-1:0];
                fsrc  = wide[WIDTH-1:0];
                carry = wide[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                wide  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & cin};
                res   = (op == OP_CMP) ? a : wide[WIDTH-1:0];
                fsrc  = wide[WIDTH-1:0];
                carry = wide[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  begin res = a & b; fsrc = a & b; end
            OP_OR:   begin res = a | b; fsrc = a | b; end
            OP_XOR:  begin res = a ^ b; fsrc = a ^ b; end
            OP_NOTA: begin res = ~a;    fsrc = ~a;    end
            OP_NOTB: begin res = ~b;    fsrc = ~b;    end
            default: begin res = '0;    fsrc = '0;    end
        endcase
        flg = '{z: (fsrc == '0), n: fsrc[WIDTH-1], c: carry, v: ovf};
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops go through
// alu_seq_core; shifts iterate one bit per cycle. Defining ALU_SEQ_MUL_EN
// adds a WIDTH-cycle shift-add multiplier on opcode D, otherwise D is reserved.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] wk_q, wk_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flg_q, flg_d;
    logic             cst_q, cst_d;

    op_e              op_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] core_res;
    flags_t           core_flg;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [WIDTH-1:0] fin_res;
    flags_t           fin_flg;

    assign op_in = op_e'(op);
    assign shamt = b[SHW-1:0];

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .op  (op_in),
        .cin (cst_q),
        .res (core_res),
        .flg (core_flg)
    );

`ifdef ALU_SEQ_MUL_EN
    // Multiplier accumulator: {high partial product, remaining multiplier bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
    logic [WIDTH:0]     mul_sum;

    // One shift-add step; wk_q holds the multiplicand for the whole operation.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? wk_q : {WIDTH{1'b0}})};
        acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
`endif

    // One shift step plus the value/flags latched when the last step finishes.
    always_comb begin
        sh_next = wk_q;
        sh_out  = 1'b0;
        case (op_q)
            OP_SHL: begin sh_next = {wk_q[WIDTH-2:0], 1'b0};         sh_out = wk_q[WIDTH-1]; end
            OP_SHR: begin sh_next = {1'b0, wk_q[WIDTH-1:1]};         sh_out = wk_q[0];       end
            OP_ASR: begin sh_next = {wk_q[WIDTH-1], wk_q[WIDTH-1:1]}; sh_out = wk_q[0];      end
            default: ;
        endcase
        fin_res = sh_next;
        fin_flg = '{z: (sh_next == '0), n: sh_next[WIDTH-1], c: sh_out, v: 1'b0};
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
            fin_res = acc_next[WIDTH-1:0];
            fin_flg = '{z: (acc_next[WIDTH-1:0] == '0), n: acc_next[WIDTH-1],
                        c: |acc_next[2*WIDTH-1:WIDTH], v: 1'b0};
        end
`endif
    end

    // FSM next state: capture on accept, iterate in BUSY, hold until complete.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wk_d     = wk_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flg_d    = flg_q;
        cst_d    = cst_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d    = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op_in;
                    if (is_shift(op_in) && (shamt == '0)) begin
                        result_d = a;
                        flg_d    = '{z: (a == '0), n: a[WIDTH-1], c: 1'b0, v: 1'b0};
                        state_d  = ST_DONE;
                    end else if (is_shift(op_in)) begin
                        wk_d    = a;
                        cnt_d   = {1'b0, shamt};
                        state_d = ST_BUSY;
`ifdef ALU_SEQ_MUL_EN
                    end else if (op_in == OP_MUL) begin
                        wk_d    = a;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_BUSY;
`endif
                    end else begin
                        result_d = core_res;
                        flg_d    = core_flg;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                wk_d  = sh_next;
`ifdef ALU_SEQ_MUL_EN
                acc_d = acc_next;
`endif
                if (cnt_q == CW'(1)) begin
                    result_d = fin_res;
                    flg_d    = fin_flg;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    cst_d   = flg_q.c;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so aborted work leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            wk_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flg_q    <= FLAGS_RST;
            cst_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wk_q     <= wk_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flg_q    <= flg_d;
            cst_q    <= cst_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign Z         = flg_q.z;
    assign N         = flg_q.n;
    assign C         = flg_q.c;
    assign V         = flg_q.v;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; SHALL be a power of two, >= 4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and opcode valid.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 op  input  4  opcode (see REQ-012).
REQ-008 out_valid  output  1  result and flags valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  registered result.
REQ-011 Z, N, C, V  output  1 each  registered flags for the held result.

Function
REQ-012 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 NOT b, 7 SHL, 8 SHR (logical), 9 ASR, A ADC, B SBC, C CMP, D MUL; E, F reserved.
REQ-013 FSM SHALL have states IDLE, BUSY, DONE; accept = in_valid & in_ready in IDLE; complete = out_valid & out_ready in DONE.
REQ-014 On accept, a, b, op SHALL be captured; ops 0-6, A-C, E-F and shifts with shamt 0 go IDLE->DONE (out_valid one cycle after accept edge).
REQ-015 Shifts SHALL use shamt = b[log2(WIDTH)-1:0]; shamt n>0 goes IDLE->BUSY, one bit per cycle, out_valid n+1 cycles after accept edge.
REQ-016 Shift C SHALL be the last bit shifted out; shamt 0 gives C=0; V=0.
REQ-017 ADD/ADC: result = a+b(+Cst) mod 2^WIDTH, C = carry-out, V = signed overflow.
REQ-018 SUB/SBC/CMP: a-b(-Cst); C = 1 on borrow (unsigned a < subtrahend); V = signed overflow; CMP result = a unchanged, flags from the subtraction.
REQ-019 Logic ops and NOT: C=0, V=0.
REQ-020 Z = (flag-source value == 0), N = its MSB, for all ops.
REQ-021 Reserved opcodes SHALL give result 0, Z=1, N=C=V=0.
REQ-022 Cst is a stored carry register, updated with C only on complete; ADC/SBC read the value held at accept.
REQ-023 In DONE, result and flags SHALL hold stable until complete; complete returns to IDLE next edge.
REQ-024 in_valid outside IDLE SHALL be ignored; no queueing.
REQ-025 Operands and op changing after accept SHALL not affect the in-flight operation.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, in_ready 1, out_valid 0, result 0, Z 1, N/C/V 0, Cst 0, counters 0.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; no output ever appears for it.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined: op D = unsigned shift-add multiply, WIDTH BUSY cycles, result = low WIDTH bits, C = 1 if high half nonzero, V=0, out_valid WIDTH+1 cycles after accept.
REQ-029 ALU_SEQ_MUL_EN undefined: op D SHALL behave as reserved (REQ-021); no multiplier logic present.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the opcode enum, FSM state enum and flag-struct typedef.
REQ-031 Sub-module alu_seq_core SHALL be the combinational add/sub/logic datapath with flag generation; shift/multiply iteration and FSM stay in alu_seq.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F b=0x01 -> result 0x80, N=1 V=1 C=0 Z=0, out_valid one cycle after accept.
REQ-033 SUB a=0x00 b=0x01 -> 0xFF, C=1 N=1 V=0; then ADC a=0x00 b=0x00 -> 0x01 (Cst=1).
REQ-034 SHL a=0x81 b=0x03 -> 0x08, C=0, out_valid 4 cycles after accept, in_ready 0 throughout.
REQ-035 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> result stable, in_ready 0, no new accept.
REQ-036 rst_n pulsed low mid-shift -> out_valid 0, in_ready 1 immediately; next op completes normally.
REQ-037 With ALU_SEQ_MUL_EN: MUL 0x10*0x11 -> 0x10, C=1, out_valid 9 cycles after accept; without it -> 0x00, Z=1.
